// File: rtl/sel_imem_pkg.sv
// sel_imem_pkg: shared constants and response record for the instruction-memory fetch path
package sel_imem_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h00000013;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            err;
  } resp_t;
endpackage

// File: rtl/sel_sync_fifo.sv
// sel_sync_fifo: small synchronous FIFO with clear and a registered head that reads 0 when empty
module sel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = empty ? '0 : mem[rp];
  // entry storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) if (do_push) mem[wp] <= push_data;
  // pointers and fill count; clear empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_push ? (wp == AW'(DEPTH-1) ? '0 : wp + 1'b1) : wp;
      rp <= do_pop ? (rp == AW'(DEPTH-1) ? '0 : rp + 1'b1) : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction array with fixed-latency fetch pipeline, credit-limited response buffer and flush
module imem_responder
  import sel_imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] resp_addr,
  output logic            resp_err,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data
);
  localparam int CAP = LATENCY + 1;
  localparam int NS = LATENCY > 1 ? LATENCY - 1 : 1;
  localparam int OW = $clog2(CAP + 1);
  logic [XLEN-1:0] mem [1 << DEPTH_LOG2];
  logic [OW-1:0] occ;
  logic [NS-1:0] sv;
  resp_t st [NS];
  resp_t req_r, in_r, head;
  logic req_err, accept, hs, in_v, empty, full, unused_wr;
  assign unused_wr = ^{wr_addr[1:0], wr_addr[XLEN-1:DEPTH_LOG2+2], full};
  assign req_err = (req_addr[1:0] != 2'b0) || (req_addr[XLEN-1:DEPTH_LOG2+2] != '0);
  assign req_r = '{addr: req_addr, data: req_err ? NOP : mem[req_addr[DEPTH_LOG2+1:2]], err: req_err};
  assign req_ready = !rst && !flush && occ < OW'(CAP);
  assign accept = req_valid && req_ready;
  assign resp_valid = !rst && !empty;
  assign hs = resp_valid && resp_ready;
  assign in_v = LATENCY == 1 ? accept : sv[NS-1];
  assign in_r = LATENCY == 1 ? req_r : st[NS-1];
  assign {resp_addr, resp_data, resp_err} = rst ? '0 : head;
  // preload port; the read below samples before this write lands, giving read-first behaviour
  always_ff @(posedge clk) if (wr_en) mem[wr_addr[DEPTH_LOG2+1:2]] <= wr_data;
  // stage valids shift toward the buffer; flush and reset drop everything in flight
  always_ff @(posedge clk) sv <= (rst || flush) ? '0 : NS'({sv, accept});
  // stage payloads, the first capturing the synchronous array read; qualified by the valids above
  always_ff @(posedge clk) begin
    st[0] <= req_r;
    for (int i = 1; i < NS; i++) st[i] <= st[i-1];
  end
  // credits cover pipeline plus buffer so the buffer can never overflow
  always_ff @(posedge clk) occ <= (rst || flush) ? '0 : occ + OW'(accept) - OW'(hs);
  sel_sync_fifo #(.WIDTH($bits(resp_t)), .DEPTH(CAP)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clear(flush),
    .push(in_v),
    .push_data(in_r),
    .pop(hs),
    .head(head),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed table-driven and sequence checks of the instruction-memory responder
module tb_imem_responder;
  localparam int L = 2;
  localparam logic [31:0] NOPW = 32'h00000013;
  logic clk = 0;
  logic rst, req_valid, req_ready, flush, resp_valid, resp_ready, resp_err, wr_en;
  logic [31:0] req_addr, resp_data, resp_addr, wr_addr, wr_data;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  imem_responder #(.DEPTH_LOG2(10), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_addr(resp_addr), .resp_err(resp_err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  typedef struct {
    logic v; logic [31:0] a; logic rdy; logic fl;
    logic e_rr; logic e_v; logic [31:0] e_d; logic [31:0] e_a; logic e_e;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(input logic v, input logic [31:0] a, input logic rdy, input logic fl,
                              input logic e_rr, input logic e_v, input logic [31:0] e_d,
                              input logic [31:0] e_a, input logic e_e);
    vec_t r;
    r.v = v; r.a = a; r.rdy = rdy; r.fl = fl;
    r.e_rr = e_rr; r.e_v = e_v; r.e_d = e_d; r.e_a = e_a; r.e_e = e_e;
    tbl.push_back(r);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic v, input logic [31:0] a, input logic rdy, input logic fl,
                     input logic e_rr, input logic e_v, input logic [31:0] e_d,
                     input logic [31:0] e_a, input logic e_e);
    req_valid = v; req_addr = a; resp_ready = rdy; flush = fl;
    #1;
    chk({tag, ".req_ready"}, {31'b0, req_ready}, {31'b0, e_rr});
    chk({tag, ".resp_valid"}, {31'b0, resp_valid}, {31'b0, e_v});
    chk({tag, ".resp_data"}, resp_data, e_d);
    chk({tag, ".resp_addr"}, resp_addr, e_a);
    chk({tag, ".resp_err"}, {31'b0, resp_err}, {31'b0, e_e});
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 8; i++)
      add(1, 32'(4 * i), 1, 0, 1, i >= 2, i >= 2 ? 32'h10000000 + 32'(i - 2) : 0, i >= 2 ? 32'(4 * (i - 2)) : 0, 0);
    add(1, 32'h2,        1, 0, 1, 1, 32'h10000006, 32'h18, 0);
    add(1, 32'h00100000, 1, 0, 1, 1, 32'h10000007, 32'h1C, 0);
    add(0, 0, 1, 0, 1, 1, NOPW, 32'h2, 1);
    add(0, 0, 1, 0, 1, 1, NOPW, 32'h00100000, 1);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 32'h4, 0, 0, 1, 0, 0, 0, 0);
    add(1, 32'h8, 0, 0, 1, 1, 32'h10000000, 32'h0, 0);
    add(1, 32'hC, 0, 0, 0, 1, 32'h10000000, 32'h0, 0);
    add(1, 32'hC, 1, 0, 0, 1, 32'h10000000, 32'h0, 0);
    add(1, 32'hC, 0, 0, 1, 1, 32'h10000001, 32'h4, 0);
    add(0, 0, 1, 0, 0, 1, 32'h10000001, 32'h4, 0);
    add(0, 0, 1, 0, 1, 1, 32'h10000002, 32'h8, 0);
    add(0, 0, 1, 0, 1, 1, 32'h10000003, 32'hC, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 32'(4 * i); wr_data = 32'h10000000 + 32'(i);
      cyc($sformatf("rst%0d", i), 1, 0, 1, 0, 0, 0, 0, 0, 0);
    end
    wr_en = 0; rst = 0;
    cyc("post_rst", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    foreach (tbl[i])
      cyc($sformatf("tbl%0d", i), tbl[i].v, tbl[i].a, tbl[i].rdy, tbl[i].fl,
          tbl[i].e_rr, tbl[i].e_v, tbl[i].e_d, tbl[i].e_a, tbl[i].e_e);
    cyc("fl0", 1, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    cyc("fl1", 1, 32'h4, 0, 0, 1, 0, 0, 0, 0);
    cyc("fl2", 1, 32'h8, 0, 0, 1, 1, 32'h10000000, 32'h0, 0);
    cyc("fl3", 1, 32'hC, 0, 1, 0, 1, 32'h10000000, 32'h0, 0);
    cyc("fl4", 1, 32'h10, 1, 0, 1, 0, 0, 0, 0);
    cyc("fl5", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("fl6", 0, 0, 1, 0, 1, 1, 32'h10000004, 32'h10, 0);
    cyc("fl7", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("fl8", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    wr_en = 1; wr_addr = 32'h14; wr_data = 32'hDEADBEEF;
    cyc("wr0", 1, 32'h14, 1, 0, 1, 0, 0, 0, 0);
    wr_en = 0;
    cyc("wr1", 1, 32'h14, 1, 0, 1, 0, 0, 0, 0);
    cyc("wr2", 0, 0, 1, 0, 1, 1, 32'h10000005, 32'h14, 0);
    cyc("wr3", 0, 0, 1, 0, 1, 1, 32'hDEADBEEF, 32'h14, 0);
    cyc("wr4", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("rs0", 1, 32'h0, 0, 0, 1, 0, 0, 0, 0);
    cyc("rs1", 1, 32'h4, 0, 0, 1, 0, 0, 0, 0);
    rst = 1;
    cyc("rs2", 1, 32'h8, 0, 0, 0, 0, 0, 0, 0);
    cyc("rs3", 1, 32'h8, 1, 0, 0, 0, 0, 0, 0);
    rst = 0;
    cyc("rs4", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("rs5", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("rs6", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("rs7", 1, 32'h1C, 1, 0, 1, 0, 0, 0, 0);
    cyc("rs8", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("rs9", 0, 0, 1, 0, 1, 1, 32'h10000007, 32'h1C, 0);
    cyc("rs10", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
